// File: rtl/morphle_loader_pkg.sv
// Shared constants and types for the Morphle configuration loader.
// Register offsets, bit indices, sequencer states, default timing.
package morphle_loader_pkg;

  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_STATUS  = 3'd1;
  localparam logic [2:0] REG_CONF    = 3'd2;
  localparam logic [2:0] REG_UIN     = 3'd3;
  localparam logic [2:0] REG_UOUT    = 3'd4;
  localparam logic [2:0] REG_CBITOUT = 3'd5;

  localparam int CTRL_BLK_RESET = 0;
  localparam int CTRL_FLUSH     = 1;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_DONE     = 1;
  localparam int STAT_OVF      = 2;
  localparam int STAT_LVL_LSB  = 4;
  localparam int STAT_ROWS_LSB = 8;

  localparam int DEF_SETUP_CYC = 2;
  localparam int DEF_PULSE_CYC = 2;
  localparam int DEF_HOLD_CYC  = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD
  } seq_state_t;

endpackage

// File: rtl/morphle_row_fifo.sv
// Small synchronous FIFO holding configuration rows.
// Flush empties it; a push at full is dropped.
module morphle_row_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: ;
      endcase
    end
  end

  // row storage, no reset needed
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/morphle_conf_loader.sv
// Wishbone-fed loader that shifts configuration rows into a yblock.
// Also drives block reset / uin and samples uout / cbitout.
module morphle_conf_loader
  import morphle_loader_pkg::*;
#(
  parameter int          BLOCKWIDTH  = 16,
  parameter int          BLOCKHEIGHT = 16,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          SETUP_CYC   = DEF_SETUP_CYC,
  parameter int          PULSE_CYC   = DEF_PULSE_CYC,
  parameter int          HOLD_CYC    = DEF_HOLD_CYC,
  parameter logic [31:0] BASE_ADR    = 32'h3000_0000
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_dat_i,
  input  logic [31:0]           wbs_adr_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic                  reset,
  output logic                  confclk,
  output logic [BLOCKWIDTH-1:0] cbitin,
  output logic [31:0]           uin,
  input  logic [31:0]           uout,
  input  logic [BLOCKWIDTH-1:0] cbitout
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  seq_state_t            state;
  logic [7:0]            tcnt;
  logic                  blk_reset;
  logic [7:0]            row_cnt;
  logic                  done;
  logic                  ovf;
  logic [31:0]           uout_q;
  logic [BLOCKWIDTH-1:0] cbitout_q;
  logic [31:0]           rdata;

  logic                  hit, acc, wr;
  logic [2:0]            ridx;
  logic                  wr_ctrl, wr_stat, wr_conf, wr_uin;
  logic                  flush, blk_fall, abort, busy;
  logic                  fifo_push, fifo_pop;
  logic                  fifo_full, fifo_empty;
  logic [BLOCKWIDTH-1:0] fifo_dout;
  logic [LW-1:0]         fifo_level;
  logic                  unused;

  assign hit  = wbs_cyc_i & wbs_stb_i
              & (wbs_adr_i[31:8] == BASE_ADR[31:8]);
  assign acc  = hit & ~wbs_ack_o;
  assign wr   = acc & wbs_we_i;
  assign ridx = wbs_adr_i[4:2];

  assign wr_ctrl = wr & (ridx == REG_CTRL) & wbs_sel_i[0];
  assign wr_stat = wr & (ridx == REG_STATUS);
  assign wr_conf = wr & (ridx == REG_CONF);
  assign wr_uin  = wr & (ridx == REG_UIN);

  assign flush    = wr_ctrl & wbs_dat_i[CTRL_FLUSH];
  assign blk_fall = wr_ctrl & blk_reset
                  & ~wbs_dat_i[CTRL_BLK_RESET];
  assign abort    = flush | (blk_reset & (state != ST_IDLE));
  assign busy     = (state != ST_IDLE) | ~fifo_empty;

  assign fifo_push = wr_conf & ~fifo_full;
  assign fifo_pop  = (state == ST_HOLD) & (tcnt == '0) & ~abort;

  assign reset  = blk_reset;
  assign unused = ^{wbs_adr_i[7:5], wbs_adr_i[1:0]};

  morphle_row_fifo #(
    .WIDTH (BLOCKWIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_i),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (abort),
    .din   (wbs_dat_i[BLOCKWIDTH-1:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // register read mux
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      (ridx == REG_CTRL): rdata[CTRL_BLK_RESET] = blk_reset;
      (ridx == REG_STATUS): begin
        rdata[STAT_BUSY]            = busy;
        rdata[STAT_DONE]            = done;
        rdata[STAT_OVF]             = ovf;
        rdata[STAT_LVL_LSB +: 4]    = 4'(fifo_level);
        rdata[STAT_ROWS_LSB +: 8]   = row_cnt;
      end
      (ridx == REG_UIN):     rdata = uin;
      (ridx == REG_UOUT):    rdata = uout_q;
      (ridx == REG_CBITOUT): rdata[BLOCKWIDTH-1:0] = cbitout_q;
      default:               rdata = '0;
    endcase
  end

  // single-cycle ack with registered read data
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= hit & ~wbs_ack_o;
      wbs_dat_o <= (acc & ~wbs_we_i) ? rdata : '0;
    end
  end

  // CTRL and UIN registers, byte-select aware
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      blk_reset <= 1'b1;
      uin       <= '0;
    end else begin
      if (wr_ctrl) blk_reset <= wbs_dat_i[CTRL_BLK_RESET];
      for (int b = 0; b < 4; b++) begin
        if (wr_uin && wbs_sel_i[b])
          uin[8*b +: 8] <= wbs_dat_i[8*b +: 8];
      end
    end
  end

  // sample yblock outputs every clock
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      uout_q    <= '0;
      cbitout_q <= '0;
    end else begin
      uout_q    <= uout;
      cbitout_q <= cbitout;
    end
  end

  // row sequencer: setup, confclk pulse, hold, then pop
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state   <= ST_IDLE;
      tcnt    <= '0;
      confclk <= 1'b0;
      cbitin  <= '0;
    end else if (abort) begin
      state   <= ST_IDLE;
      tcnt    <= '0;
      confclk <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty && !blk_reset) begin
            state  <= ST_SETUP;
            cbitin <= fifo_dout;
            tcnt   <= 8'(SETUP_CYC - 1);
          end
        end
        ST_SETUP: begin
          if (tcnt == '0) begin
            state   <= ST_PULSE;
            confclk <= 1'b1;
            tcnt    <= 8'(PULSE_CYC - 1);
          end else begin
            tcnt <= tcnt - 8'd1;
          end
        end
        ST_PULSE: begin
          if (tcnt == '0) begin
            state   <= ST_HOLD;
            confclk <= 1'b0;
            tcnt    <= 8'(HOLD_CYC - 1);
          end else begin
            tcnt <= tcnt - 8'd1;
          end
        end
        ST_HOLD: begin
          if (tcnt == '0) state <= ST_IDLE;
          else            tcnt  <= tcnt - 8'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // row count, done and overflow flags
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      row_cnt <= '0;
      done    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (blk_fall) begin
        row_cnt <= '0;
        done    <= 1'b0;
      end else if (fifo_pop) begin
        if (row_cnt != 8'hFF) row_cnt <= row_cnt + 8'd1;
        if (({1'b0, row_cnt} + 9'd1) == 9'(BLOCKHEIGHT))
          done <= 1'b1;
        else if (wr_stat && wbs_dat_i[STAT_DONE])
          done <= 1'b0;
      end else if (wr_stat && wbs_dat_i[STAT_DONE]) begin
        done <= 1'b0;
      end
      if (wr_conf && fifo_full)
        ovf <= 1'b1;
      else if (wr_stat && wbs_dat_i[STAT_OVF])
        ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_morphle_conf_loader.sv
// Bench for morphle_conf_loader: directed cases plus random rounds
// checked against a transaction-level model of the loader.
module tb_morphle_conf_loader;

  localparam logic [31:0] A_CTRL = 32'h3000_0000;
  localparam logic [31:0] A_STAT = 32'h3000_0004;
  localparam logic [31:0] A_CONF = 32'h3000_0008;
  localparam logic [31:0] A_UIN  = 32'h3000_000C;
  localparam logic [31:0] A_UOUT = 32'h3000_0010;
  localparam logic [31:0] A_CBO  = 32'h3000_0014;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        stb = 0, cyc = 0, we = 0;
  logic [3:0]  sel = 0;
  logic [31:0] dat_w = 0, adr = 0;
  logic        ack;
  logic [31:0] dat_r;
  logic        reset, confclk;
  logic [15:0] cbitin;
  logic [31:0] uin, uout;
  logic [15:0] cbitout = '0;
  logic [15:0] chain [16] = '{default: '0};

  int n_tests = 0, n_fail = 0;
  int cyc_n = 0;

  logic [15:0] mq [$];
  logic [15:0] cap_q [$];
  logic [15:0] sent_q [$];
  int          mrows = 0;
  bit          mdone = 0, movf = 0;
  logic [31:0] muin = 0;

  logic        cc_prev = 0;
  logic [15:0] cb_h1 = 0, cb_h2 = 0;
  int          high_n = 0, rise_cyc = 0, fall_cyc = 0;
  bit          abort_ok = 0;

  morphle_conf_loader dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst_n),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_dat_i (dat_w),
    .wbs_adr_i (adr),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_r),
    .reset     (reset),
    .confclk   (confclk),
    .cbitin    (cbitin),
    .uin       (uin),
    .uout      (uout),
    .cbitout   (cbitout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // yblock model: uout loops uin, rows shift down a 16-deep chain
  assign uout = uin;
  always @(posedge confclk) begin
    cbitout <= chain[15];
    for (int i = 15; i > 0; i--) chain[i] <= chain[i-1];
    chain[0] <= cbitin;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // confclk timing monitor
  always @(negedge clk) begin
    if (confclk && !cc_prev) begin
      chk("setup", {30'b0, cb_h1 == cbitin, cb_h2 == cbitin}, 32'd3);
      cap_q.push_back(cbitin);
      rise_cyc = cyc_n;
      high_n = 1;
    end else if (confclk) begin
      high_n++;
    end
    if (!confclk && cc_prev) begin
      fall_cyc = cyc_n;
      if (!abort_ok) begin
        chk("pulse_w", high_n, 2);
        chk("hold", cbitin, cb_h1);
      end
    end
    cb_h2 = cb_h1;
    cb_h1 = cbitin;
    cc_prev = confclk;
  end

  function automatic logic [31:0] st_exp(bit b, bit d, bit o,
                                         int lvl, int rows);
    return {16'h0, 8'(rows), 4'(lvl), 1'b0, o, d, b};
  endfunction

  task automatic bus(input logic [31:0] a, input logic w,
                     input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] r, output bit ok);
    adr = a; we = w; dat_w = d; sel = s;
    cyc = 1; stb = 1; ok = 0; r = '0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (ack) begin
        ok = 1;
        r = dat_r;
        break;
      end
    end
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic wrs(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s);
    logic [31:0] r;
    bit ok;
    bus(a, 1'b1, d, s, r, ok);
    chk("wr_ack", {31'b0, ok}, 1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wrs(a, d, 4'hF);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] r);
    bit ok;
    bus(a, 1'b0, 32'h0, 4'hF, r, ok);
    chk("rd_ack", {31'b0, ok}, 1);
  endtask

  task automatic chk_stat(input string tag, input bit b);
    logic [31:0] r;
    rd(A_STAT, r);
    chk(tag, r, st_exp(b, mdone, movf, mq.size(), mrows));
  endtask

  task automatic drain();
    logic [31:0] r = '1;
    for (int k = 0; k < 40; k++) begin
      rd(A_STAT, r);
      if (!r[0]) break;
    end
    chk("drain", {31'b0, r[0]}, 0);
  endtask

  // compare delivered rows with the model queue, then retire them
  task automatic chk_rows();
    chk("nrows", cap_q.size(), mq.size());
    for (int i = 0; i < mq.size() && i < cap_q.size(); i++)
      chk("row", cap_q[i], mq[i]);
    foreach (mq[i]) begin
      sent_q.push_back(mq[i]);
      if (mrows != 255) begin
        mrows++;
        if (mrows == 16) mdone = 1;
      end
    end
    mq.delete();
    cap_q.delete();
  endtask

  task automatic release_blk();
    wr(A_CTRL, 32'h0);
    mrows = 0;
    mdone = 0;
  endtask

  task automatic chk_cbo();
    logic [31:0] r;
    logic [15:0] e;
    int n = sent_q.size();
    e = (n >= 17) ? sent_q[n-17] : 16'h0;
    rd(A_CBO, r);
    chk("cbitout", r, {16'h0, e});
  endtask

  task automatic chk_uin(input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    wrs(A_UIN, d, s);
    for (int b = 0; b < 4; b++)
      if (s[b]) muin[8*b +: 8] = d[8*b +: 8];
    chk("uin_port", uin, muin);
    rd(A_UOUT, r);
    chk("uout_rd", r, muin);
  endtask

  // load n rows under block reset, optionally flush, then release
  task automatic round(input int n, input bit fl);
    logic [31:0] d;
    wr(A_CTRL, 32'h1);
    cap_q.delete();
    for (int i = 0; i < n; i++) begin
      d = $urandom;
      wr(A_CONF, d);
      if (mq.size() < 4) mq.push_back(d[15:0]);
      else movf = 1;
    end
    chk_stat("held_stat", mq.size() > 0);
    chk("no_cc", cap_q.size(), 0);
    if (fl) begin
      wr(A_CTRL, 32'h3);
      mq.delete();
      chk_stat("flushed", 0);
    end
    release_blk();
    drain();
    chk_rows();
    chk_stat("round_stat", 0);
    if ($urandom_range(0, 1) == 1) begin
      wr(A_STAT, 32'h4);
      movf = 0;
      chk_stat("ovf_clr", 0);
    end
    chk_cbo();
    chk_uin($urandom, 4'($urandom_range(0, 15)));
  endtask

  task automatic wait_rise(input string tag);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (confclk) break;
    end
    chk(tag, {31'b0, confclk}, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] d;
    int w;
    bit ok;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'b0, ack}, 0);
    chk("rst_dat", dat_r, 0);
    chk("rst_reset", {31'b0, reset}, 1);
    chk("rst_cc", {31'b0, confclk}, 0);
    chk("rst_cbitin", cbitin, 0);
    chk("rst_uin", uin, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;

    rd(A_STAT, r);
    chk("t1_stat", r, 0);
    rd(A_CTRL, r);
    chk("t1_ctrl", r, 1);
    wrs(A_CTRL, 32'h0, 4'b1110);
    rd(A_CTRL, r);
    chk("ctrl_sel", r, 1);
    chk("reset_held", {31'b0, reset}, 1);
    bus(32'h3000_0100, 1'b1, 32'h0, 4'hF, r, ok);
    chk("unsel_ack", {31'b0, ok}, 0);

    release_blk();
    chk("reset_rel", {31'b0, reset}, 0);
    cap_q.delete();
    wr(A_CONF, 32'hFFFF_A5C3);
    w = cyc_n;
    mq.push_back(16'hA5C3);
    repeat (6) begin @(posedge clk); #1; end
    rd(A_STAT, r);
    chk("t2_stat6", r, st_exp(0, 0, 0, 0, 1));
    chk("t2_rise", rise_cyc - w, 3);
    chk("t2_high", fall_cyc - rise_cyc, 2);
    chk_rows();
    rd(A_CONF, r);
    chk("conf_rd0", r, 0);

    d = $urandom;
    wr(A_CONF, d);
    w = cyc_n;
    mq.push_back(d[15:0]);
    repeat (5) begin @(posedge clk); #1; end
    rd(A_STAT, r);
    chk("t2_stat5", r, st_exp(1, 0, 0, 1, 1));
    drain();
    chk_rows();
    chk_stat("t2_end", 0);

    wr(A_CTRL, 32'h1);
    release_blk();
    cap_q.delete();
    for (int i = 0; i < 16; i++) begin
      r = 32'hF0;
      for (int k = 0; k < 20; k++) begin
        rd(A_STAT, r);
        if (r[7:4] < 4) break;
      end
      chk("t3_poll", {31'b0, r[7:4] < 4}, 1);
      d = $urandom;
      wr(A_CONF, d);
      mq.push_back(d[15:0]);
    end
    drain();
    chk_rows();
    chk("t3_done", {31'b0, mdone}, 1);
    chk_stat("t3_stat", 0);
    wr(A_STAT, 32'h2);
    mdone = 0;
    chk_stat("t3_dclr", 0);

    round(5, 0);

    cap_q.delete();
    d = $urandom;
    wr(A_CONF, d);
    wr(A_CONF, $urandom);
    wait_rise("t5_rise");
    abort_ok = 1;
    wr(A_CTRL, 32'h2);
    chk("t5_cc_lo", {31'b0, confclk}, 0);
    mq.delete();
    chk_stat("t5_stat", 0);
    chk("t5_ncap", cap_q.size(), 1);
    if (cap_q.size() > 0) chk("t5_row", cap_q[0], d[15:0]);
    sent_q.push_back(d[15:0]);
    cap_q.delete();
    abort_ok = 0;

    chk_uin(32'hDEAD_BEEF, 4'hF);
    chk_uin(32'h1234_5678, 4'b0101);

    for (int i = 0; i < 8; i++)
      round($urandom_range(0, 6), $urandom_range(0, 3) == 0);

    cap_q.delete();
    wr(A_CONF, $urandom);
    wait_rise("ar_rise");
    abort_ok = 1;
    @(negedge clk) rst_n = 0;
    #1;
    chk("ar_cc", {31'b0, confclk}, 0);
    chk("ar_reset", {31'b0, reset}, 1);
    chk("ar_cbitin", cbitin, 0);
    chk("ar_uin", uin, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    abort_ok = 0;
    rd(A_STAT, r);
    chk("ar_stat", r, 0);
    rd(A_CTRL, r);
    chk("ar_ctrl", r, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
